// File: rtl/cache2vias_ctrl.sv
// rtl/cache2vias_ctrl.sv - 2-way set-associative cache sequencing controller with LRU replacement.
// Optional write-back mode with dirty bits: define CACHE_WRITEBACK_EN (default is write-through).
module cache2vias_ctrl #(
    parameter int TAG_W  = 2,
    parameter int IDX_W  = 3,
    parameter int DATA_W = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cpu_req,
    input  logic                   cpu_wren,
    input  logic [TAG_W+IDX_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0]      cpu_wdata,
    output logic [DATA_W-1:0]      cpu_rdata,
    output logic                   cpu_ready,
    output logic                   cpu_hit,
    output logic                   cpu_miss,
    output logic                   busy,
    output logic                   mem_req,
    output logic                   mem_wren,
    output logic [TAG_W+IDX_W-1:0] mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    input  logic                   mem_ack
);

    localparam int ADDR_W = TAG_W + IDX_W;
    localparam int SETS   = 1 << IDX_W;
`ifdef CACHE_WRITEBACK_EN
    localparam bit WB_MODE = 1'b1;
`else
    localparam bit WB_MODE = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WRITEBACK, FILL, WRITETHRU, RESPOND
    } state_t;

    state_t state, state_next;

    logic              req_wren;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [DATA_W-1:0] req_wdata;
    logic              hit_r;
    logic              victim_r;
    logic [DATA_W-1:0] rdata_r;

    logic [SETS-1:0]   valid [2];
    logic [SETS-1:0]   lru;
    logic [TAG_W-1:0]  tag_mem  [2][SETS];
    logic [DATA_W-1:0] data_mem [2][SETS];

    logic              hit0, hit1, hit, hit_way, victim_sel, victim_dirty;
    logic              wr_en, wr_way, lru_en, lru_way, rdata_en;
    logic [DATA_W-1:0] wr_data, rdata_val;

    assign hit0    = valid[0][req_idx] && (tag_mem[0][req_idx] == req_tag);
    assign hit1    = valid[1][req_idx] && (tag_mem[1][req_idx] == req_tag);
    assign hit     = hit0 || hit1;
    assign hit_way = hit1;
    // Fill empty ways first (way 0 preferred), otherwise evict the least recently used.
    assign victim_sel = !valid[0][req_idx] ? 1'b0 :
                        !valid[1][req_idx] ? 1'b1 : lru[req_idx];

`ifdef CACHE_WRITEBACK_EN
    logic [SETS-1:0] dirty [2];

    assign victim_dirty = valid[victim_sel][req_idx] && dirty[victim_sel][req_idx];

    // Writes install dirty lines, fills install clean ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            dirty[0] <= '0;
            dirty[1] <= '0;
        end else if (wr_en) begin
            dirty[wr_way][req_idx] <= (state != FILL);
        end else if (state == WRITEBACK && mem_ack) begin
            dirty[victim_r][req_idx] <= 1'b0;
        end
    end
`else
    assign victim_dirty = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            req_wren  <= 1'b0;
            req_tag   <= '0;
            req_idx   <= '0;
            req_wdata <= '0;
            hit_r     <= 1'b0;
            victim_r  <= 1'b0;
            rdata_r   <= '0;
            valid[0]  <= '0;
            valid[1]  <= '0;
            lru       <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && cpu_req) begin
                req_wren  <= cpu_wren;
                req_tag   <= cpu_addr[ADDR_W-1:IDX_W];
                req_idx   <= cpu_addr[IDX_W-1:0];
                req_wdata <= cpu_wdata;
            end
            if (state == LOOKUP) begin
                hit_r    <= hit;
                victim_r <= victim_sel;
            end
            if (wr_en)
                valid[wr_way][req_idx] <= 1'b1;
            if (lru_en)
                lru[req_idx] <= ~lru_way;
            if (rdata_en)
                rdata_r <= rdata_val;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_mem[wr_way][req_idx]  <= req_tag;
            data_mem[wr_way][req_idx] <= wr_data;
        end
    end

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_way     = victim_r;
        wr_data    = req_wdata;
        lru_en     = 1'b0;
        lru_way    = victim_r;
        rdata_en   = 1'b0;
        rdata_val  = mem_rdata;
        mem_req    = 1'b0;
        mem_wren   = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (cpu_req)
                    state_next = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    lru_en  = 1'b1;
                    lru_way = hit_way;
                    if (req_wren) begin
                        wr_en      = 1'b1;
                        wr_way     = hit_way;
                        state_next = WB_MODE ? RESPOND : WRITETHRU;
                    end else begin
                        rdata_en   = 1'b1;
                        rdata_val  = data_mem[hit_way][req_idx];
                        state_next = RESPOND;
                    end
                end else if (victim_dirty) begin
                    state_next = WRITEBACK;
                end else if (req_wren) begin
                    // One-word lines: write-allocate needs no fetch.
                    wr_en      = 1'b1;
                    wr_way     = victim_sel;
                    lru_en     = 1'b1;
                    lru_way    = victim_sel;
                    state_next = WB_MODE ? RESPOND : WRITETHRU;
                end else begin
                    state_next = FILL;
                end
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_wren  = 1'b1;
                mem_addr  = {tag_mem[victim_r][req_idx], req_idx};
                mem_wdata = data_mem[victim_r][req_idx];
                if (mem_ack) begin
                    if (req_wren) begin
                        wr_en      = 1'b1;
                        lru_en     = 1'b1;
                        state_next = RESPOND;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_idx};
                if (mem_ack) begin
                    wr_en      = 1'b1;
                    wr_data    = mem_rdata;
                    lru_en     = 1'b1;
                    rdata_en   = 1'b1;
                    state_next = RESPOND;
                end
            end
            WRITETHRU: begin
                mem_req   = 1'b1;
                mem_wren  = 1'b1;
                mem_addr  = {req_tag, req_idx};
                mem_wdata = req_wdata;
                if (mem_ack)
                    state_next = RESPOND;
            end
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign cpu_rdata = rdata_r;
    assign cpu_ready = (state == RESPOND);
    assign cpu_hit   = (state == RESPOND) && hit_r;
    assign cpu_miss  = (state == RESPOND) && !hit_r;
    assign busy      = (state != IDLE);

endmodule

// File: doc/cache2vias_ctrl.md
Name: cache2vias_ctrl

Overview:
Sequencing controller for the 2-way set-associative cache: 8 sets, 2 ways, 1-byte lines, 5-bit byte address split as tag = addr[4:3] and index = addr[2:0].
- Owns the cache state: valid, tag and data per way, plus one LRU bit per set.
- Accepts CPU requests over a req/ready handshake.
- Services misses and evictions against backing memory over a req/ack handshake.
- Sits between the processor datapath and main memory, replacing the free-running write-on-miss scheme with an explicit FSM.

Parameters:
- TAG_W, 2, tag width; address width = TAG_W+IDX_W.
- IDX_W, 3, index width; sets = 2^IDX_W.
- DATA_W, 8, line/word width.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- cpu_req  in  1  CPU request valid; sampled only in IDLE.
- cpu_wren  in  1  1 = write, 0 = read; captured with cpu_req.
- cpu_addr  in  TAG_W+IDX_W  byte address; captured with cpu_req.
- cpu_wdata  in  DATA_W  write data; captured with cpu_req.
- cpu_rdata  out  DATA_W  read data; valid when cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_hit  out  1  lookup result; valid with cpu_ready.
- cpu_miss  out  1  ~cpu_hit; valid with cpu_ready.
- busy  out  1  high in every state except IDLE.
- mem_req  out  1  memory request; held until mem_ack.
- mem_wren  out  1  memory write strobe qualifier.
- mem_addr  out  TAG_W+IDX_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; sampled when mem_ack=1.
- mem_ack  in  1  memory completion, one cycle.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs 0; state goes to IDLE.
  - All valid, dirty and LRU bits cleared. Data and tag contents are don't-care.
  - Reset asserted mid-transaction aborts it: mem_req drops in the cycle after reset is sampled, and no CPU response is issued.
- States: IDLE, LOOKUP, WRITEBACK, FILL, WRITETHRU, RESPOND.
- IDLE:
  - cpu_req=1 captures addr, wren and wdata into registers, then goes to LOOKUP.
  - cpu_req is ignored in all other states; CPU holds or re-issues it.
- LOOKUP (exactly 1 cycle):
  - Way w hits if valid[w][idx] and tag[w][idx]==captured tag. Both ways hitting cannot occur; the design must never install duplicate tags.
  - Hit, read: latch data[w] into cpu_rdata. Set lru[idx] = ~w. Go to RESPOND.
  - Hit, write: data[w] = wdata. Set lru[idx] = ~w. With CACHE_WRITEBACK_EN go to RESPOND and set dirty[w]=1; otherwise go to WRITETHRU.
  - Miss, victim selection: the first invalid way, with way 0 taking priority; if both ways are valid, the way lru[idx]. With CACHE_WRITEBACK_EN, a victim that is valid and dirty goes to WRITEBACK first.
  - Miss, read: go to FILL.
  - Miss, write: allocate without fetch, because the line equals one word. Install valid=1, tag, data=wdata into the victim and set lru[idx] = ~victim. Then go to RESPOND (writeback mode, dirty=1) or WRITETHRU.
- WRITEBACK:
  - Drive mem_req=1, mem_wren=1, mem_addr={victim tag, idx}, mem_wdata=victim data.
  - On mem_ack: clear dirty, then go to FILL (read miss) or to the write-allocate step above.
- FILL:
  - Drive mem_req=1, mem_wren=0, mem_addr=captured addr.
  - On mem_ack: install valid=1, tag, data=mem_rdata into the victim; set lru[idx] = ~victim; cpu_rdata = mem_rdata; go to RESPOND.
- WRITETHRU:
  - Drive mem_req=1, mem_wren=1, mem_addr=captured addr, mem_wdata=wdata.
  - On mem_ack, go to RESPOND.
- RESPOND (1 cycle):
  - cpu_ready=1; cpu_hit/cpu_miss reflect the LOOKUP result.
  - Next state is IDLE. A new cpu_req is accepted in the following IDLE cycle.
- Memory handshake:
  - mem_req, mem_addr, mem_wdata and mem_wren stay stable from assertion through the mem_ack cycle.
  - mem_req is 0 in the cycle after mem_ack.
  - mem_ack arriving while mem_req=0 is ignored.
  - No timeout.
- Latency (request sampled at edge k):
  - Hit: cpu_ready in cycle k+2.
  - Miss: k+2+(memory cycles per transaction).
- The LRU bit updates only on hit or install, never on a pure writeback.

Optional Feature:
- CACHE_WRITEBACK_EN defined:
  - Write-back with per-way dirty bits; write hits do not touch memory.
  - A dirty victim is written to memory before replacement.
- Not defined:
  - Write-through; no dirty bits are synthesized and WRITEBACK is unreachable.
  - Every write, hit or miss, passes through WRITETHRU.

Test Plan:
- Reset, then read 0x05 with memory[0x05]=0xA5 and 2-cycle ack → FILL with mem_addr=0x05, cpu_ready with cpu_miss=1 and cpu_rdata=0xA5. Re-read 0x05 → cpu_hit=1, cpu_rdata=0xA5, cpu_ready 2 cycles after req, mem_req stays 0.
- Reads to 0x01, 0x09, 0x01, then 0x11 (all set 1) → 0x11 replaces way holding tag 1 (0x09, the LRU). Re-read 0x01 → hit.
- With CACHE_WRITEBACK_EN: write 0x33 to 0x02 (miss, no memory access), then reads to 0x0A and 0x12 → WRITEBACK with mem_addr=0x02, mem_wdata=0x33 precedes FILL of 0x12.
- Without the macro: write 0x5C to 0x07 → WRITETHRU with mem_wren=1, mem_addr=0x07, mem_wdata=0x5C; cpu_ready only after mem_ack.
- Assert cpu_req again while busy=1 during FILL → request ignored, no second cpu_ready.
- Assert reset during FILL with mem_ack withheld → mem_req=0 the next cycle. Re-read the previously cached address → cpu_miss=1, confirming all valid bits were cleared.
